pixel_l1_buffer: RTL and testbench

PIXEL_L1_BUFFER -- requirements
Module: pixel_l1_buffer

---
 rtl/pixel_l1_pkg.sv | 41 ++++
 rtl/pixel_l1_fifo.sv | 70 +++++++
 rtl/pixel_l1_buffer.sv | 118 +++++++++++
 tb/tb_pixel_l1_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_l1_pkg.sv
// Shared types and constants for the pixel L1 trigger buffer.
// The entry payload layout is also the low part of every emitted word.
package pixel_l1_pkg;

    localparam int TOA_W          = 10;
    localparam int TOT_W          = 9;
    localparam int CAL_W          = 10;
    localparam int TAG_W          = 8;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int PAYLOAD_W = 1 + TOA_W + TOT_W + CAL_W;
    // Bit 38 is a spare MSB, always driven 0; the tag sits directly below it.
    localparam int WORD_W    = 1 + TAG_W + PAYLOAD_W;

    typedef struct packed {
        logic             err;
        logic [TOA_W-1:0] toa;
        logic [TOT_W-1:0] tot;
        logic [CAL_W-1:0] cal;
    } l1Payload_t;

    typedef struct packed {
        logic       hit;
        l1Payload_t payload;
    } l1Entry_t;

    typedef struct packed {
        logic             spare;
        logic [TAG_W-1:0] tag;
        l1Payload_t       payload;
    } l1Word_t;

    // Inclusive window test; an inverted window (lower > upper) never passes.
    function automatic logic toaInWindow(input logic [TOA_W-1:0] toa,
                                         input logic [TOA_W-1:0] lower,
                                         input logic [TOA_W-1:0] upper);
        return (toa >= lower) && (toa <= upper);
    endfunction

endpackage

// File: rtl/pixel_l1_fifo.sv
// Output FIFO for the pixel L1 buffer. The head word is presented on a
// registered dout/doutValid pair; a word leaves when doutValid & popReady.
// A push into a full FIFO is accepted only if a pop happens the same cycle.
module pixel_l1_fifo
    import pixel_l1_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReady,
    output logic [WIDTH-1:0] dout,
    output logic             doutValid,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    rdPtrNext;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             pop;
    logic             doPush;
    logic [WIDTH-1:0] headNext;

    assign full      = (count == CW'(DEPTH));
    assign pop       = doutValid & popReady;
    assign doPush    = push & (~full | pop);
    assign rdPtrNext = rdPtr + PW'(pop);
    assign countNext = count + CW'(doPush) - CW'(pop);
    // When the FIFO drains to nothing this cycle, the new head is the word
    // being pushed right now, which is not in mem yet.
    assign headNext  = (count == CW'(pop)) ? pushData : mem[rdPtrNext];

    // Storage write; data only, no reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            doutValid <= 1'b0;
            dout      <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            rdPtr     <= rdPtrNext;
            count     <= countNext;
            doutValid <= (countNext != '0);
            if (countNext != '0) begin
                dout <= headNext;
            end
        end
    end

endmodule

// File: rtl/pixel_l1_buffer.sv
// Pixel L1 trigger buffer: a circular buffer written every clk40 cycle with
// the current TDC result, read back 'latency' cycles later on l1a, and
// matched hits queued into an output FIFO tagged with the L1A count.
// Optional feature: define PIXEL_L1_TOA_WINDOW_EN to store only hits whose
// TOA lies in [toaLower, toaUpper]; without it the window ports are ignored.
module pixel_l1_buffer
    import pixel_l1_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk40,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     hitFlag,
    input  logic [TOA_W-1:0]         TOA_codeReg,
    input  logic [TOT_W-1:0]         TOT_codeReg,
    input  logic [CAL_W-1:0]         Cal_codeReg,
    input  logic                     TOAerrorFlagReg,
    input  logic                     TOTerrorFlagReg,
    input  logic                     CalerrorFlagReg,
    input  logic [$clog2(DEPTH)-1:0] latency,
    input  logic                     l1a,
    input  logic [TOA_W-1:0]         toaLower,
    input  logic [TOA_W-1:0]         toaUpper,
    output logic [WORD_W-1:0]        dout,
    output logic                     doutValid,
    input  logic                     doutReady,
    output logic                     overflowFlag,
    output logic [TAG_W-1:0]         l1aTag
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rdAddr;
    logic [DEPTH-1:0] hitMem;
    l1Payload_t       payloadMem [DEPTH];
    logic             windowPass;
    l1Entry_t         wrEntry;
    l1Word_t          pushWord;
    logic             push;
    logic             fifoFull;
    logic             drop;

`ifdef PIXEL_L1_TOA_WINDOW_EN
    assign windowPass = toaInWindow(TOA_codeReg, toaLower, toaUpper);
`else
    logic unusedWindow;
    assign windowPass   = 1'b1;
    assign unusedWindow = ^{toaLower, toaUpper};
`endif

    // Build this cycle's entry; a non-hit stores an all-zero payload.
    always_comb begin
        wrEntry     = '0;
        wrEntry.hit = hitFlag & enable & windowPass;
        if (wrEntry.hit) begin
            wrEntry.payload.err = TOAerrorFlagReg | TOTerrorFlagReg | CalerrorFlagReg;
            wrEntry.payload.toa = TOA_codeReg;
            wrEntry.payload.tot = TOT_codeReg;
            wrEntry.payload.cal = Cal_codeReg;
        end
    end

    // Write pointer and hit bits; hit bits are reset so stale data never matches.
    always_ff @(posedge clk40 or negedge resetn) begin
        if (!resetn) begin
            wptr   <= '0;
            hitMem <= '0;
        end else begin
            hitMem[wptr] <= wrEntry.hit;
            wptr         <= wptr + 1'b1;
        end
    end

    // Payload storage; only ever read when its hit bit is set, so no reset.
    always_ff @(posedge clk40) begin
        payloadMem[wptr] <= wrEntry.payload;
    end

    // Read happens before this cycle's write, so latency 0 sees the entry
    // written a full DEPTH cycles ago.
    assign rdAddr   = wptr - latency;
    assign push     = l1a & hitMem[rdAddr];
    assign pushWord = {1'b0, l1aTag, payloadMem[rdAddr]};
    assign drop     = push & fifoFull & ~(doutValid & doutReady);

    // L1A counter and sticky overflow flag.
    always_ff @(posedge clk40 or negedge resetn) begin
        if (!resetn) begin
            l1aTag       <= '0;
            overflowFlag <= 1'b0;
        end else begin
            if (l1a) begin
                l1aTag <= l1aTag + 1'b1;
            end
            if (drop) begin
                overflowFlag <= 1'b1;
            end
        end
    end

    pixel_l1_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk       (clk40),
        .resetn    (resetn),
        .push      (push),
        .pushData  (pushWord),
        .popReady  (doutReady),
        .dout      (dout),
        .doutValid (doutValid),
        .full      (fifoFull)
    );

endmodule

// File: tb/tb_pixel_l1_buffer.sv
// Scoreboard bench for pixel_l1_buffer: expected words are queued when the
// matching l1a is driven and compared as the DUT hands them out.
`timescale 1ns/1ps
module tb_pixel_l1_buffer;
    import pixel_l1_pkg::*;

    localparam int DEPTH      = 64;
    localparam int FIFO_DEPTH = 4;
`ifdef PIXEL_L1_TOA_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    logic                     clk40 = 1'b0;
    logic                     resetn;
    logic                     enable;
    logic                     hitFlag;
    logic [TOA_W-1:0]         TOA_codeReg;
    logic [TOT_W-1:0]         TOT_codeReg;
    logic [CAL_W-1:0]         Cal_codeReg;
    logic                     TOAerrorFlagReg;
    logic                     TOTerrorFlagReg;
    logic                     CalerrorFlagReg;
    logic [$clog2(DEPTH)-1:0] latency;
    logic                     l1a;
    logic [TOA_W-1:0]         toaLower;
    logic [TOA_W-1:0]         toaUpper;
    logic [WORD_W-1:0]        dout;
    logic                     doutValid;
    logic                     doutReady;
    logic                     overflowFlag;
    logic [TAG_W-1:0]         l1aTag;

    int                nTests = 0;
    int                nFail  = 0;
    logic [WORD_W-1:0] sbQ [$];
    logic [WORD_W-1:0] monExp;
    logic [7:0]        expTag;

    always #12 clk40 = ~clk40;

    pixel_l1_buffer #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk40           (clk40),
        .resetn          (resetn),
        .enable          (enable),
        .hitFlag         (hitFlag),
        .TOA_codeReg     (TOA_codeReg),
        .TOT_codeReg     (TOT_codeReg),
        .Cal_codeReg     (Cal_codeReg),
        .TOAerrorFlagReg (TOAerrorFlagReg),
        .TOTerrorFlagReg (TOTerrorFlagReg),
        .CalerrorFlagReg (CalerrorFlagReg),
        .latency         (latency),
        .l1a             (l1a),
        .toaLower        (toaLower),
        .toaUpper        (toaUpper),
        .dout            (dout),
        .doutValid       (doutValid),
        .doutReady       (doutReady),
        .overflowFlag    (overflowFlag),
        .l1aTag          (l1aTag)
    );

    task automatic chkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mkWord(input logic [7:0] tag, input logic err,
                                                 input logic [9:0] toa, input logic [8:0] tot,
                                                 input logic [9:0] cal);
        return {1'b0, tag, err, toa, tot, cal};
    endfunction

    // A word is consumed at the next rising edge whenever valid & ready here.
    always @(negedge clk40) begin
        if (resetn && doutValid && doutReady) begin
            if (sbQ.size() == 0) begin
                chkEq("unexpected", 64'(doutValid), 64'd0);
            end else begin
                monExp = sbQ.pop_front();
                chkEq("dout", 64'(dout), 64'(monExp));
            end
        end
    end

    initial begin
        #(25 * 60000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk40);
            #1;
        end
    endtask

    task automatic driveHit(input logic [9:0] toa, input logic [8:0] tot, input logic [9:0] cal,
                            input logic [2:0] errs, input logic en);
        hitFlag = 1'b1;  enable = en;
        TOA_codeReg = toa;  TOT_codeReg = tot;  Cal_codeReg = cal;
        {TOAerrorFlagReg, TOTerrorFlagReg, CalerrorFlagReg} = errs;
        cyc(1);
        hitFlag = 1'b0;  enable = 1'b1;
        TOA_codeReg = '0;  TOT_codeReg = '0;  Cal_codeReg = '0;
        {TOAerrorFlagReg, TOTerrorFlagReg, CalerrorFlagReg} = 3'b000;
    endtask

    task automatic pulseL1a(input bit expPush, input logic err, input logic [9:0] toa,
                            input logic [8:0] tot, input logic [9:0] cal);
        l1a = 1'b1;
        if (expPush) sbQ.push_back(mkWord(expTag, err, toa, tot, cal));
        cyc(1);
        l1a = 1'b0;
        expTag++;
    endtask

    task automatic hitThenL1a(input logic [9:0] toa, input logic [8:0] tot, input logic [9:0] cal,
                              input logic [2:0] errs, input logic en, input logic [5:0] lat,
                              input bit expPush);
        latency = lat;
        driveHit(toa, tot, cal, errs, en);
        cyc((lat == 0) ? DEPTH - 1 : int'(lat) - 1);
        pulseL1a(expPush, |errs, toa, tot, cal);
    endtask

    // n hits on consecutive cycles, then n l1a on consecutive cycles (latency 10).
    task automatic burst(input int n, input bit readyAtLast, input int nExp);
        latency = 6'd10;
        for (int i = 0; i < n; i++)
            driveHit(10'(32'h100 + i), 9'(i), 10'(32'h3FF - i), 3'b000, 1'b1);
        cyc(10 - n);
        for (int i = 0; i < n; i++) begin
            if (readyAtLast && i == n - 1) doutReady = 1'b1;
            pulseL1a(i < nExp, 1'b0, 10'(32'h100 + i), 9'(i), 10'(32'h3FF - i));
        end
    endtask

    task automatic waitDrain(input string tag);
        int k = 0;
        while (sbQ.size() != 0 && k < 200) begin
            cyc(1);
            k++;
        end
        cyc(2);
        chkEq(tag, 64'(sbQ.size()), 64'd0);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        cyc(2);
        resetn = 1'b1;
        sbQ.delete();
        expTag = '0;
    endtask

    int  winToa [5] = '{99, 100, 200, 201, 150};
    bit  expWin;

    initial begin
        resetn = 1'b0;  enable = 1'b1;  hitFlag = 1'b0;
        TOA_codeReg = '0;  TOT_codeReg = '0;  Cal_codeReg = '0;
        TOAerrorFlagReg = 1'b0;  TOTerrorFlagReg = 1'b0;  CalerrorFlagReg = 1'b0;
        latency = 6'd10;  l1a = 1'b0;  toaLower = '0;  toaUpper = 10'h3FF;
        doutReady = 1'b1;  expTag = '0;
        cyc(2);
        chkEq("rstValid", 64'(doutValid), 64'd0);
        chkEq("rstTag", 64'(l1aTag), 64'd0);
        chkEq("rstOvf", 64'(overflowFlag), 64'd0);
        chkEq("rstDout", 64'(dout), 64'd0);
        resetn = 1'b1;
        cyc(5);

        // Basic hit/readout with one-cycle push latency
        hitThenL1a(10'h155, 9'h0AA, 10'h200, 3'b000, 1'b1, 6'd10, 1'b1);
        chkEq("latValid", 64'(doutValid), 64'd1);
        waitDrain("drainBasic");
        chkEq("tag1", 64'(l1aTag), 64'(expTag));

        // Error flags, short/long latencies, enable low
        hitThenL1a(10'h3FF, 9'h1FF, 10'h3FF, 3'b010, 1'b1, 6'd5, 1'b1);
        hitThenL1a(10'h001, 9'h002, 10'h003, 3'b100, 1'b1, 6'd1, 1'b1);
        hitThenL1a(10'h2A5, 9'h15A, 10'h0F0, 3'b001, 1'b1, 6'd63, 1'b1);
        hitThenL1a(10'h0AB, 9'h0CD, 10'h0EF, 3'b000, 1'b0, 6'd10, 1'b0);
        waitDrain("drainMisc");

        // Back-to-back l1a, the last one reading a no-hit entry
        burst(2, 1'b0, 2);
        pulseL1a(1'b0, 1'b0, 10'h0, 9'h0, 10'h0);
        waitDrain("drainB2B");
        chkEq("tagB2B", 64'(l1aTag), 64'(expTag));

        // Full FIFO with simultaneous pop: nothing dropped
        doutReady = 1'b0;
        burst(5, 1'b1, 5);
        chkEq("ovfNoDrop", 64'(overflowFlag), 64'd0);
        waitDrain("drainFullPop");
        chkEq("ovfNoDrop2", 64'(overflowFlag), 64'd0);

        // Overflow: fifth word dropped, head held stable under backpressure
        doutReady = 1'b0;
        burst(5, 1'b0, 4);
        cyc(1);
        chkEq("ovfSet", 64'(overflowFlag), 64'd1);
        chkEq("ovfValid", 64'(doutValid), 64'd1);
        cyc(3);
        chkEq("holdDout", 64'(dout), 64'(sbQ[0]));
        chkEq("holdValid", 64'(doutValid), 64'd1);
        doutReady = 1'b1;
        waitDrain("drainOvf");
        chkEq("ovfSticky", 64'(overflowFlag), 64'd1);

        // Asynchronous reset mid-burst discards queued words
        doutReady = 1'b0;
        burst(3, 1'b0, 3);
        cyc(1);
        chkEq("preRstValid", 64'(doutValid), 64'd1);
        #5;
        resetn = 1'b0;
        #1;
        chkEq("asyncValid", 64'(doutValid), 64'd0);
        chkEq("asyncTag", 64'(l1aTag), 64'd0);
        chkEq("asyncOvf", 64'(overflowFlag), 64'd0);
        sbQ.delete();
        expTag = '0;
        @(posedge clk40);
        #1;
        resetn = 1'b1;
        doutReady = 1'b1;
        cyc(5);
        pulseL1a(1'b0, 1'b0, 10'h0, 9'h0, 10'h0);
        latency = 6'd0;
        pulseL1a(1'b0, 1'b0, 10'h0, 9'h0, 10'h0);
        cyc(3);
        chkEq("postRstNoPush", 64'(doutValid), 64'd0);
        chkEq("postRstTag", 64'(l1aTag), 64'd2);

        // latency 0 reads the entry written DEPTH cycles earlier (entry 0)
        doReset();
        hitThenL1a(10'h1C3, 9'h055, 10'h2AA, 3'b000, 1'b1, 6'd0, 1'b1);
        waitDrain("drainLat0");

        // TOA window qualification
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                toaLower = 10'd100;  toaUpper = 10'd200;
                expWin = !WIN_EN || (winToa[i] >= 100 && winToa[i] <= 200);
            end else begin
                toaLower = 10'd300;  toaUpper = 10'd100;
                expWin = !WIN_EN;
            end
            hitThenL1a(10'(winToa[i]), 9'h011, 10'h022, 3'b000, 1'b1, 6'd10, expWin);
        end
        toaLower = '0;  toaUpper = 10'h3FF;
        waitDrain("drainWin");

        // Tag wraps 255 -> 0
        cyc(DEPTH);
        latency = 6'd10;
        for (int i = 0; i < 256; i++)
            pulseL1a(1'b0, 1'b0, 10'h0, 9'h0, 10'h0);
        chkEq("tagWrap", 64'(l1aTag), 64'(expTag));
        cyc(DEPTH);
        hitThenL1a(10'h0F1, 9'h1E2, 10'h3C4, 3'b111, 1'b1, 6'd20, 1'b1);
        waitDrain("drainWrap");
        chkEq("ovfFinal", 64'(overflowFlag), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
